// File: rtl/up_counter_cascade.sv
// Multi-digit synchronous modulo up counter with registered carry-out and sticky overflow.
// Optional build macro COUNT_SAT_EN: hold at all-(MOD-1) instead of wrapping.
module up_counter_cascade #(
  parameter int DIGITS = 2,
  parameter int MOD    = 10
) (
  input  logic                  CLK,
  input  logic                  MR,
  input  logic                  EN,
  input  logic                  LD,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  CO,
  output logic                  OVF
);

  localparam logic [4:0] MOD_W = 5'(MOD);
  localparam logic [3:0] TOP   = 4'(MOD - 1);

  logic [DIGITS:0]       carry;
  logic [4*DIGITS-1:0]   inc_q;
  logic [4*DIGITS-1:0]   ld_q;
  logic                  full;

  assign carry[0] = 1'b1;

  // An out-of-range digit wraps to 0 but never passes a carry upward.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] din;
    assign cur            = Q[4*k +: 4];
    assign din            = D[4*k +: 4];
    assign carry[k+1]     = carry[k] & (cur == TOP);
    assign inc_q[4*k +: 4] = !carry[k] ? cur :
                             ({1'b0, cur} >= (MOD_W - 5'd1)) ? 4'd0 : cur + 4'd1;
    assign ld_q[4*k +: 4]  = ({1'b0, din} >= MOD_W) ? 4'd0 : din;
  end

  assign full = carry[DIGITS];

  always_ff @(posedge CLK) begin
    if (MR) begin
      Q   <= '0;
      CO  <= 1'b0;
      OVF <= 1'b0;
    end else if (LD) begin
      Q   <= ld_q;
      CO  <= 1'b0;
      OVF <= 1'b0;
    end else if (EN) begin
      if (full) begin
`ifdef COUNT_SAT_EN
        Q   <= Q;
        CO  <= 1'b0;
`else
        Q   <= inc_q;
        CO  <= 1'b1;
`endif
        OVF <= 1'b1;
      end else begin
        Q   <= inc_q;
        CO  <= 1'b0;
      end
    end else begin
      CO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_counter_cascade.sv
// Scoreboard bench for up_counter_cascade: integer reference model feeds an expected
// queue at each drive; an independent monitor compares {Q, CO, OVF} after every edge.
module tb_up_counter_cascade;

  localparam int DIGITS = 2;
  localparam int MOD    = 10;
  localparam int W      = 4*DIGITS + 2;

  logic                CLK = 1'b0;
  logic                MR  = 1'b0;
  logic                EN  = 1'b0;
  logic                LD  = 1'b0;
  logic [4*DIGITS-1:0] D   = '0;
  logic [4*DIGITS-1:0] Q;
  logic                CO;
  logic                OVF;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference state: the counter as a plain integer in [0, MOD**DIGITS).
  longint m_val = 0;
  bit     m_co  = 0;
  bit     m_ovf = 0;
  longint maxv;

  up_counter_cascade #(.DIGITS(DIGITS), .MOD(MOD)) dut (
    .CLK(CLK), .MR(MR), .EN(EN), .LD(LD), .D(D), .Q(Q), .CO(CO), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  function automatic logic [4*DIGITS-1:0] to_digits(input longint v);
    logic [4*DIGITS-1:0] r;
    longint t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % MOD);
      t = t / MOD;
    end
    return r;
  endfunction

  function automatic longint from_load(input logic [4*DIGITS-1:0] d);
    longint v;
    longint w;
    int dig;
    v = 0;
    w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      dig = int'(d[4*k +: 4]);
      if (dig >= MOD) dig = 0;
      v = v + dig * w;
      w = w * MOD;
    end
    return v;
  endfunction

  task automatic step(input bit mr, input bit en, input bit ld, input logic [4*DIGITS-1:0] d);
    @(negedge CLK);
    MR = mr; EN = en; LD = ld; D = d;
    if (mr) begin
      m_val = 0; m_co = 0; m_ovf = 0;
    end else if (ld) begin
      m_val = from_load(d); m_co = 0; m_ovf = 0;
    end else if (en) begin
      if (m_val == maxv - 1) begin
`ifdef COUNT_SAT_EN
        m_co = 0;
`else
        m_val = 0;
        m_co  = 1;
`endif
        m_ovf = 1;
      end else begin
        m_val = m_val + 1;
        m_co  = 0;
      end
    end else begin
      m_co = 0;
    end
    exp_q.push_back({to_digits(m_val), m_co, m_ovf});
  endtask

  // Monitor: one result per clock edge, compared after outputs settle.
  always @(posedge CLK) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({Q, CO, OVF} === e) passed++;
      else $display("FAIL cycle_out t=%0t: got Q=%h CO=%b OVF=%b, expected Q=%h CO=%b OVF=%b",
                    $time, Q, CO, OVF, e[W-1:2], e[1], e[0]);
    end
  end

  initial begin
    maxv = 1;
    for (int k = 0; k < DIGITS; k++) maxv = maxv * MOD;

    // Reset from an arbitrary state, EN held high.
    step(0, 0, 1, 8'h63);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    // Inter-digit carry 00 -> 10.
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    // Full wrap then one more count.
    step(0, 0, 1, 8'h98);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    // Priority and illegal-digit load.
    step(0, 1, 1, 8'h45);
    step(1, 1, 1, 8'h45);
    step(0, 0, 1, 8'hA7);
    step(0, 0, 1, 8'hFF);
    // Idle hold.
    step(0, 0, 1, 8'h37);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00);
    // Saturation (or wrap in the default build), then load clears OVF.
    step(0, 0, 1, 8'h99);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    // Reset mid-count at the wrap point: no CO.
    step(0, 0, 1, 8'h99);
    step(1, 1, 0, 8'h00);

    // Randomized traffic, biased toward loads near the top of the range.
    for (int i = 0; i < 800; i++) begin
      bit mr, en, ld;
      logic [4*DIGITS-1:0] d;
      mr = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) d = to_digits(maxv - 1 - longint'($urandom_range(0, 3)));
      else d = 8'($urandom);
      step(mr, en, ld, d);
    end

    step(0, 0, 0, 8'h00);
    repeat (3) @(negedge CLK);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
